shift_tx_sequencer: RTL and testbench
=====================================

Name: shift_tx_sequencer

Overview:
Control stage directly upstream of the team's 8-bit bidirectional shift register (`ShiftRegister`: ports d[7:0], i, c, l, r, q[7:0]; l&r = parallel load, l only = shift toward MSB, r only = shift toward LSB, neither = hold).
- Accepts bytes over a valid/ready handshake and drives the register's control pins.
- Reads back the register's q and emits a UART-style serial frame: start bit, 8 data bits, stop bit(s).
- The shift register holds the data; this block owns timing, framing and the handshake.

Parameters:
BIT_CYCLES, 4, clock cycles per serial bit; legal range >= 1.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
MSB_FIRST, 0, 0 = LSB first (shift toward LSB, txd taken from sr_q[0]); 1 = MSB first (shift toward MSB, txd taken from sr_q[7]).

Ports:
c      input   1  clock; all state changes on rising edge.
rst    input   1  asynchronous, active-high reset.
data   input   8  byte to transmit; sampled only on accept.
valid  input   1  data valid.
ready  output  1  block can accept a byte.
sr_d   output  8  to ShiftRegister d.
sr_l   output  1  to ShiftRegister l.
sr_r   output  1  to ShiftRegister r.
sr_i   output  1  to ShiftRegister i; serial fill bit.
sr_q   input   8  from ShiftRegister q.
txd    output  1  serial line.
busy   output  1  frame in progress.
done   output  1  one-cycle pulse on the last cycle of a frame.

Behaviour:
- Clock and reset: single clock c; reset rst is asynchronous and active-high.
- Reset values (applied immediately on rst, held while rst = 1):
  - state IDLE; counters 0.
  - ready = 1, busy = 0, done = 0, txd = 1.
  - sr_l = 0, sr_r = 0, sr_i = 1, sr_d = 0.
- All outputs except txd are registered. txd is registered in IDLE/START/STOP; in DATA it is a mux of sr_q.
- sr_i is constant 1, so vacated register bits fill with idle level.
- Accept: handshake completes when valid & ready are high at a rising edge. data is captured into sr_d. valid while ready = 0 is ignored; no queuing.
- States (B = BIT_CYCLES, S = STOP_BITS):
  - IDLE: ready = 1, txd = 1, sr_l = sr_r = 0.
    - On accept -> LOAD.
  - LOAD: exactly 1 cycle.
    - sr_l = sr_r = 1; register loads sr_d at the following edge.
    - ready = 0, busy = 1, txd = 1.
    - -> START.
  - START: B cycles with txd = 0. -> DATA.
  - DATA: 8 bit periods of B cycles each.
    - txd = sr_q[0] (MSB_FIRST = 0) or sr_q[7] (MSB_FIRST = 1).
    - On the last cycle of bit periods 0..6, a shift command is active for exactly that cycle:
      - MSB_FIRST = 0: sr_r = 1, sr_l = 0.
      - MSB_FIRST = 1: sr_l = 1, sr_r = 0.
    - The register therefore presents the next bit from the first cycle of the next period.
    - No shift is issued after bit 7. -> STOP.
  - STOP: S*B cycles with txd = 1.
    - done = 1 on the final STOP cycle.
    - -> IDLE.
- Latency and frame length:
  - Accept at edge k: LOAD during cycle k+1; start bit spans cycles k+2 .. k+1+B.
  - Accept to IDLE is 1 + (9+S)*B cycles.
  - ready rises the cycle after done; minimum inter-frame gap is 1 cycle (IDLE) + 1 cycle (LOAD) at txd = 1.
- Per frame, exactly 1 load command and exactly 7 shift commands. Never l=1,r=1 outside LOAD.
- B = 1: a shift command is active on every DATA cycle except the last. Counters must not underflow.
- Reset mid-frame:
  - Aborts immediately; txd returns to 1 asynchronously; no done pulse.
  - Shift register contents are not cleared (that register has no reset); the next LOAD overwrites them.
- Bit counter 3 bits. Cycle counter width clog2(B) with minimum 1. Stop counter covers S*B.

Test Plan:
- Reset checks (bench instantiates real ShiftRegister wired to sr_*):
  - Assert rst mid-cycle -> immediately ready = 1, busy = 0, txd = 1, sr_l = sr_r = 0, sr_i = 1.
- LSB-first frame, B=4, S=1, send 0xA5 at edge k:
  - sr_l = sr_r = 1 in cycle k+1.
  - txd = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1, each 4 cycles, then 1 for 4 cycles.
  - done at cycle k+41; exactly 7 shift pulses.
- Busy rejection:
  - Hold valid = 1 with data 0x3C throughout frame of 0xA5 -> 0x3C accepted only after ready returns.
  - Its LOAD occurs exactly 2 cycles after the first frame's done.
- MSB_FIRST=1, B=2, S=2, send 0x81:
  - Data bits 1,0,0,0,0,0,0,1.
  - Shift pulses use sr_l = 1, sr_r = 0.
  - Stop bits last 4 cycles.
- Back-to-back, B=1: send 0x00 then 0xFF with valid held high.
  - txd stream per frame: 0, 00000000, 1; then gap 1,1; then 0, 11111111, 1.
  - ready high only in the single IDLE cycles.
- Reset mid-frame: assert rst during DATA bit 3 of 0x5A.
  - txd = 1 at once, no done pulse.
  - After release, send 0x0F -> correct frame 0, 11110000, 1 despite stale register contents.

Source files
------------

// File: rtl/shift_tx_sequencer.sv
// Control stage in front of the 8-bit ShiftRegister: accepts bytes on valid/ready,
// drives the register's load/shift pins and frames its output as a UART-style serial line.
module shift_tx_sequencer #(
   parameter int BIT_CYCLES = 4,
   parameter int STOP_BITS  = 1,
   parameter int MSB_FIRST  = 0
) (
   input  logic       c,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic [7:0] sr_d,
   output logic       sr_l,
   output logic       sr_r,
   output logic       sr_i,
   input  logic [7:0] sr_q,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int SB = STOP_BITS * BIT_CYCLES;
   localparam int SW = (SB > 1) ? $clog2(SB) : 1;
   localparam logic [CW-1:0] CYC_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [SW-1:0] STOP_LAST = SW'(SB - 1);
   localparam bit MSB = (MSB_FIRST != 0);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cyc_cnt, cyc_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [SW-1:0] stop_cnt, stop_n;
   logic          load_n, shift_n;
   logic          txd_q;
   logic          accept;
   logic          sr_q_unused;

   // Handshake: a byte is taken on a rising edge where valid and ready are both high.
   // ready is high exactly while IDLE; valid while ready is low is ignored, nothing queues.
   assign accept = valid && ready;

   // During DATA the line follows the register's outgoing end directly.
   assign txd = (state == DATA) ? (MSB ? sr_q[7] : sr_q[0]) : txd_q;
   assign sr_q_unused = ^sr_q[6:1];

   always_comb begin
      state_n = state;
      cyc_n   = cyc_cnt;
      bit_n   = bit_cnt;
      stop_n  = stop_cnt;
      case (state)
         IDLE: begin
            if (accept) state_n = LOAD;
         end
         LOAD: begin
            state_n = START;
            cyc_n   = '0;
         end
         START: begin
            if (cyc_cnt == CYC_LAST) begin
               state_n = DATA;
               cyc_n   = '0;
               bit_n   = '0;
            end else begin
               cyc_n = cyc_cnt + CW'(1);
            end
         end
         DATA: begin
            if (cyc_cnt == CYC_LAST) begin
               cyc_n = '0;
               if (bit_cnt == 3'd7) begin
                  state_n = STOP;
                  stop_n  = '0;
               end else begin
                  bit_n = bit_cnt + 3'd1;
               end
            end else begin
               cyc_n = cyc_cnt + CW'(1);
            end
         end
         STOP: begin
            if (stop_cnt == STOP_LAST) state_n = IDLE;
            else                       stop_n  = stop_cnt + SW'(1);
         end
         default: state_n = IDLE;
      endcase
      // Outputs are registered from the next state, so a shift lands on the period's last cycle.
      load_n  = (state_n == LOAD);
      shift_n = (state_n == DATA) && (cyc_n == CYC_LAST) && (bit_n != 3'd7);
   end

   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         bit_cnt  <= '0;
         stop_cnt <= '0;
         ready    <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         txd_q    <= 1'b1;
         sr_l     <= 1'b0;
         sr_r     <= 1'b0;
         sr_i     <= 1'b1;
         sr_d     <= 8'h00;
      end else begin
         state    <= state_n;
         cyc_cnt  <= cyc_n;
         bit_cnt  <= bit_n;
         stop_cnt <= stop_n;
         ready    <= (state_n == IDLE);
         busy     <= (state_n != IDLE);
         done     <= (state_n == STOP) && (stop_n == STOP_LAST);
         txd_q    <= (state_n != START);
         sr_l     <= load_n || (shift_n && MSB);
         sr_r     <= load_n || (shift_n && !MSB);
         sr_i     <= 1'b1;
         if (accept) sr_d <= data;
      end
   end

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// Bench for shift_tx_sequencer: three parameterisations, each driving a behavioural
// ShiftRegister, with traces compared cycle by cycle against a frame-level model.
module tb_shift_tx_sequencer;

   logic       c = 1'b0;
   logic       rst;
   logic [7:0] data  [3];
   logic       valid [3];
   logic       ready [3];
   logic [7:0] sr_d  [3];
   logic       sr_l  [3];
   logic       sr_r  [3];
   logic       sr_i  [3];
   logic [7:0] sr_q  [3];
   logic       txd   [3];
   logic       busy  [3];
   logic       done  [3];

   int checks = 0;
   int errors = 0;

   always #5 c = ~c;

   shift_tx_sequencer #(.BIT_CYCLES(4), .STOP_BITS(1), .MSB_FIRST(0)) u0 (
      .c(c), .rst(rst), .data(data[0]), .valid(valid[0]), .ready(ready[0]),
      .sr_d(sr_d[0]), .sr_l(sr_l[0]), .sr_r(sr_r[0]), .sr_i(sr_i[0]), .sr_q(sr_q[0]),
      .txd(txd[0]), .busy(busy[0]), .done(done[0]));
   shift_tx_sequencer #(.BIT_CYCLES(2), .STOP_BITS(2), .MSB_FIRST(1)) u1 (
      .c(c), .rst(rst), .data(data[1]), .valid(valid[1]), .ready(ready[1]),
      .sr_d(sr_d[1]), .sr_l(sr_l[1]), .sr_r(sr_r[1]), .sr_i(sr_i[1]), .sr_q(sr_q[1]),
      .txd(txd[1]), .busy(busy[1]), .done(done[1]));
   shift_tx_sequencer #(.BIT_CYCLES(1), .STOP_BITS(1), .MSB_FIRST(0)) u2 (
      .c(c), .rst(rst), .data(data[2]), .valid(valid[2]), .ready(ready[2]),
      .sr_d(sr_d[2]), .sr_l(sr_l[2]), .sr_r(sr_r[2]), .sr_i(sr_i[2]), .sr_q(sr_q[2]),
      .txd(txd[2]), .busy(busy[2]), .done(done[2]));

   // ShiftRegister behaviour; it has no reset, contents survive an rst of the sequencer
   always_ff @(posedge c) begin
      for (int g = 0; g < 3; g++) begin
         case ({sr_l[g], sr_r[g]})
            2'b11:   sr_q[g] <= sr_d[g];
            2'b10:   sr_q[g] <= {sr_q[g][6:0], sr_i[g]};
            2'b01:   sr_q[g] <= {sr_i[g], sr_q[g][7:1]};
            default: sr_q[g] <= sr_q[g];
         endcase
      end
   end

   function automatic int b_of(input int u);
      case (u) 0: return 4; 1: return 2; default: return 1; endcase
   endfunction
   function automatic int s_of(input int u);
      case (u) 1: return 2; default: return 1; endcase
   endfunction
   function automatic bit m_of(input int u);
      return (u == 1);
   endfunction

   // ---------------- expected per-cycle trace (model) ----------------
   logic [0:0] exp_q [$];
   logic       exp_sh[$];
   logic       exp_ld[$];
   logic       exp_dn[$];
   logic       exp_rd[$];

   task automatic clear_model();
      exp_q.delete(); exp_sh.delete(); exp_ld.delete(); exp_dn.delete(); exp_rd.delete();
   endtask

   task automatic push_exp(input logic t, input logic sh, input logic ld, input logic dn, input logic rd);
      exp_q.push_back(t); exp_sh.push_back(sh); exp_ld.push_back(ld);
      exp_dn.push_back(dn); exp_rd.push_back(rd);
   endtask

   // One frame as seen from the line: idle, load, start, 8 data bits, stop bits, idle.
   task automatic model_frame(input int u, input logic [7:0] b, input bit first);
      int  bc = b_of(u);
      int  sc = s_of(u);
      logic bitv;
      if (first) push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < bc; k++) push_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 8; j++) begin
         bitv = m_of(u) ? b[7-j] : b[j];
         for (int k = 0; k < bc; k++)
            push_exp(bitv, (j < 7) && (k == bc - 1), 1'b0, 1'b0, 1'b0);
      end
      for (int k = 0; k < sc * bc; k++) push_exp(1'b1, 1'b0, 1'b0, k == sc * bc - 1, 1'b0);
      push_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // ---------------- monitor ----------------
   int   mon_u   = 0;
   int   rec_len = 0;
   logic tr_txd[$], tr_l[$], tr_r[$], tr_done[$], tr_ready[$], tr_busy[$];

   always @(negedge c) begin
      if (tr_txd.size() < rec_len) begin
         tr_txd.push_back(txd[mon_u]);
         tr_l.push_back(sr_l[mon_u]);
         tr_r.push_back(sr_r[mon_u]);
         tr_done.push_back(done[mon_u]);
         tr_ready.push_back(ready[mon_u]);
         tr_busy.push_back(busy[mon_u]);
      end
   end

   // ---------------- driver ----------------
   logic [7:0] tx_q[$];

   task automatic drive_stream(input int u);
      int   guard = 0;
      logic r;
      while (tx_q.size() > 0 && guard < 500) begin
         data[u]  = tx_q[0];
         valid[u] = 1'b1;
         @(negedge c);
         r = ready[u];
         @(posedge c);
         #1;
         guard++;
         if (r) void'(tx_q.pop_front());
      end
      valid[u] = 1'b0;
      checks++;
      if (tx_q.size() != 0) begin
         $display("FAIL drive_timeout unit %0d: %0d bytes never accepted, required 0", u, tx_q.size());
         errors++;
         tx_q.delete();
      end
   endtask

   task automatic run_capture(input int u);
      @(posedge c);
      #1;
      mon_u   = u;
      rec_len = 0;
      tr_txd.delete(); tr_l.delete(); tr_r.delete();
      tr_done.delete(); tr_ready.delete(); tr_busy.delete();
      rec_len = exp_q.size();
      fork
         drive_stream(u);
         begin
            repeat (rec_len) @(negedge c);
            #1;
         end
      join
   endtask

   // Count of disagreeing cycles per signal: txd, shift, load, done, ready, busy.
   string sig_name[6] = '{"txd", "shift", "load", "done", "ready", "busy"};
   int    bad_cnt[6];
   int    first_bad[6];
   logic  first_got[6];
   logic  first_exp[6];

   task automatic diff_trace();
      logic [5:0] got, want;
      for (int s = 0; s < 6; s++) begin
         bad_cnt[s] = 0; first_bad[s] = -1; first_got[s] = 1'b0; first_exp[s] = 1'b0;
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         got  = {tr_busy[i], tr_ready[i], tr_done[i], tr_l[i] & tr_r[i], tr_l[i] ^ tr_r[i], tr_txd[i]};
         want = {!exp_rd[i], exp_rd[i], exp_dn[i], exp_ld[i], exp_sh[i], exp_q[i][0]};
         for (int s = 0; s < 6; s++) begin
            if (got[s] !== want[s]) begin
               if (bad_cnt[s] == 0) begin
                  first_bad[s] = i; first_got[s] = got[s]; first_exp[s] = want[s];
               end
               bad_cnt[s]++;
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int u = 0; u < 3; u++) begin
         valid[u] = 1'b0;
         data[u]  = 8'h00;
      end
      rst = 1'b1;
      #1;
      for (int u = 0; u < 3; u++) begin
         checks++;
         if ({ready[u], busy[u], done[u], txd[u], sr_l[u], sr_r[u], sr_i[u]} !== 7'b1001001 || sr_d[u] !== 8'h00) begin
            $display("FAIL reset_initial unit %0d: ready,busy,done,txd,l,r,i=%b sr_d=%h, required 1001001 sr_d=00",
                     u, {ready[u], busy[u], done[u], txd[u], sr_l[u], sr_r[u], sr_i[u]}, sr_d[u]);
            errors++;
         end
      end
      repeat (2) @(negedge c);
      #2 rst = 1'b0;
      @(posedge c);
      #1;
      for (int u = 0; u < 3; u++) begin
         data[u]  = 8'hFF;
         valid[u] = 1'b1;
      end
      @(posedge c);
      #1;
      for (int u = 0; u < 3; u++) valid[u] = 1'b0;
      #3;
      for (int u = 0; u < 3; u++) begin
         checks++;
         if ({busy[u], sr_l[u], sr_r[u]} !== 3'b111) begin
            $display("FAIL load_before_reset unit %0d: busy,l,r=%b, required 111", u, {busy[u], sr_l[u], sr_r[u]});
            errors++;
         end
      end
      rst = 1'b1;
      #1;
      for (int u = 0; u < 3; u++) begin
         checks++;
         if ({ready[u], busy[u], done[u], txd[u], sr_l[u], sr_r[u], sr_i[u]} !== 7'b1001001 || sr_d[u] !== 8'h00) begin
            $display("FAIL reset_async unit %0d: ready,busy,done,txd,l,r,i=%b sr_d=%h, required 1001001 sr_d=00",
                     u, {ready[u], busy[u], done[u], txd[u], sr_l[u], sr_r[u], sr_i[u]}, sr_d[u]);
            errors++;
         end
      end
      repeat (2) @(negedge c);
      #2 rst = 1'b0;
   endtask

   task automatic test_lsb_frame();
      logic [0:7] seq = 8'b10100101;
      int di = -1, rcnt = 0, lcnt = 0;
      clear_model();
      model_frame(0, 8'hA5, 1'b1);
      tx_q = '{8'hA5};
      run_capture(0);
      diff_trace();
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (bad_cnt[s] !== 0) begin
            $display("FAIL lsb_frame %s: %0d wrong cycles, first at cycle %0d got %b required %b",
                     sig_name[s], bad_cnt[s], first_bad[s], first_got[s], first_exp[s]);
            errors++;
         end
      end
      for (int j = 0; j < 8; j++) begin
         checks++;
         if (tr_txd[7 + 4 * j] !== seq[j]) begin
            $display("FAIL lsb_bit%0d: txd %b, required %b", j, tr_txd[7 + 4 * j], seq[j]);
            errors++;
         end
      end
      for (int i = 0; i < tr_done.size(); i++) begin
         if (tr_done[i] === 1'b1 && di < 0) di = i;
         if (tr_r[i] === 1'b1 && tr_l[i] === 1'b0) rcnt++;
         if (tr_l[i] === 1'b1 && tr_r[i] === 1'b0) lcnt++;
      end
      checks++;
      if (di !== 41) begin
         $display("FAIL lsb_done_cycle: done at k+%0d, required k+41", di);
         errors++;
      end
      checks++;
      if (rcnt !== 7 || lcnt !== 0) begin
         $display("FAIL lsb_shift_count: r-shifts %0d l-shifts %0d, required 7 and 0", rcnt, lcnt);
         errors++;
      end
   endtask

   task automatic test_busy_reject();
      int loads[$];
      clear_model();
      model_frame(0, 8'hA5, 1'b1);
      model_frame(0, 8'h3C, 1'b0);
      tx_q = '{8'hA5, 8'h3C};
      run_capture(0);
      diff_trace();
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (bad_cnt[s] !== 0) begin
            $display("FAIL busy_reject %s: %0d wrong cycles, first at cycle %0d got %b required %b",
                     sig_name[s], bad_cnt[s], first_bad[s], first_got[s], first_exp[s]);
            errors++;
         end
      end
      for (int i = 0; i < tr_l.size(); i++)
         if (tr_l[i] === 1'b1 && tr_r[i] === 1'b1) loads.push_back(i);
      checks++;
      if (loads.size() != 2 || loads[0] != 1 || loads[1] != 43) begin
         $display("FAIL busy_reject_loads: %0d loads, second at k+%0d, required 2 loads at k+1 and k+43",
                  loads.size(), (loads.size() > 1) ? loads[1] : -1);
         errors++;
      end
   endtask

   task automatic test_msb_frame();
      int lcnt = 0, rcnt = 0, stop_hi = 0;
      clear_model();
      model_frame(1, 8'h81, 1'b1);
      tx_q = '{8'h81};
      run_capture(1);
      diff_trace();
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (bad_cnt[s] !== 0) begin
            $display("FAIL msb_frame %s: %0d wrong cycles, first at cycle %0d got %b required %b",
                     sig_name[s], bad_cnt[s], first_bad[s], first_got[s], first_exp[s]);
            errors++;
         end
      end
      for (int i = 0; i < tr_l.size(); i++) begin
         if (tr_l[i] === 1'b1 && tr_r[i] === 1'b0) lcnt++;
         if (tr_r[i] === 1'b1 && tr_l[i] === 1'b0) rcnt++;
      end
      for (int i = 20; i < 24; i++) if (tr_txd[i] === 1'b1) stop_hi++;
      checks++;
      if (lcnt !== 7 || rcnt !== 0) begin
         $display("FAIL msb_shift_dir: l-shifts %0d r-shifts %0d, required 7 and 0", lcnt, rcnt);
         errors++;
      end
      checks++;
      if (stop_hi !== 4 || tr_done[23] !== 1'b1) begin
         $display("FAIL msb_stop: %0d high stop cycles done=%b, required 4 and done=1 on the fourth", stop_hi, tr_done[23]);
         errors++;
      end
   endtask

   task automatic test_back_to_back();
      int rdy = 0;
      clear_model();
      model_frame(2, 8'h00, 1'b1);
      model_frame(2, 8'hFF, 1'b0);
      tx_q = '{8'h00, 8'hFF};
      run_capture(2);
      diff_trace();
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (bad_cnt[s] !== 0) begin
            $display("FAIL back_to_back %s: %0d wrong cycles, first at cycle %0d got %b required %b",
                     sig_name[s], bad_cnt[s], first_bad[s], first_got[s], first_exp[s]);
            errors++;
         end
      end
      for (int i = 0; i < tr_ready.size(); i++) if (tr_ready[i] === 1'b1) rdy++;
      checks++;
      if (rdy !== 3 || tr_ready[12] !== 1'b1) begin
         $display("FAIL b2b_ready: %0d ready cycles, ready at gap=%b, required 3 and 1", rdy, tr_ready[12]);
         errors++;
      end
   endtask

   task automatic test_random();
      int u, n;
      logic [7:0] b0, b1;
      for (int it = 0; it < 8; it++) begin
         u  = $urandom_range(0, 2);
         n  = $urandom_range(1, 2);
         b0 = 8'($urandom_range(0, 255));
         b1 = 8'($urandom_range(0, 255));
         clear_model();
         model_frame(u, b0, 1'b1);
         tx_q = '{b0};
         if (n == 2) begin
            model_frame(u, b1, 1'b0);
            tx_q.push_back(b1);
         end
         run_capture(u);
         diff_trace();
         for (int s = 0; s < 6; s++) begin
            checks++;
            if (bad_cnt[s] !== 0) begin
               $display("FAIL random%0d unit %0d bytes %h %h %s: %0d wrong cycles, first at cycle %0d got %b required %b",
                        it, u, b0, b1, sig_name[s], bad_cnt[s], first_bad[s], first_got[s], first_exp[s]);
               errors++;
            end
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] b = 8'h5A;
      logic       saw_done = 1'b0;
      @(posedge c);
      #1;
      data[0]  = b;
      valid[0] = 1'b1;
      @(posedge c);
      #1;
      valid[0] = 1'b0;
      repeat (18) @(posedge c);
      #3;
      checks++;
      if (busy[0] !== 1'b1 || txd[0] !== b[3]) begin
         $display("FAIL midframe_bit3: busy=%b txd=%b, required busy=1 txd=%b", busy[0], txd[0], b[3]);
         errors++;
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({txd[0], busy[0], ready[0], done[0]} !== 4'b1010) begin
         $display("FAIL midframe_abort: txd,busy,ready,done=%b, required 1010", {txd[0], busy[0], ready[0], done[0]});
         errors++;
      end
      repeat (2) @(negedge c);
      #2 rst = 1'b0;
      repeat (4) begin
         @(negedge c);
         if (done[0] !== 1'b0 || ready[0] !== 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin
         $display("FAIL midframe_after: done pulse or not ready after abort, required idle with done=0");
         errors++;
      end
      clear_model();
      model_frame(0, 8'h0F, 1'b1);
      tx_q = '{8'h0F};
      run_capture(0);
      diff_trace();
      for (int s = 0; s < 6; s++) begin
         checks++;
         if (bad_cnt[s] !== 0) begin
            $display("FAIL after_abort_frame %s: %0d wrong cycles, first at cycle %0d got %b required %b",
                     sig_name[s], bad_cnt[s], first_bad[s], first_got[s], first_exp[s]);
            errors++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_lsb_frame();
      test_busy_reject();
      test_msb_frame();
      test_back_to_back();
      test_random();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, required completion before 500000");
      $fatal(1);
   end

endmodule
